// File: rtl/apb4_cmd_master_pkg.sv
// Shared types for the APB4 command master: FSM encoding and the canonical
// 32-bit command/response transaction views.
package apb4_cmd_master_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [2:0]            prot;
    } cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb4_cmd_master.sv
// Single-outstanding APB4 requester: one command in, one SETUP/ACCESS transfer,
// one response out, with a PREADY watchdog so a hung slave cannot stall the fabric.
module apb4_cmd_master
    import apb4_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_write_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic [2:0]              cmd_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
    // A one-bit counter keeps the datapath legal when the watchdog is disabled.
    localparam int CNT_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_expired;

    assign w_expired = TO_EN && (r_cnt == CNT_LAST);

    // Transfer sequencer: command latch, APB phase control, watchdog and response hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_cnt         <= {CNT_W{1'b0}};
            r_paddr       <= {ADDR_WIDTH{1'b0}};
            r_pprot       <= 3'b000;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= {DATA_WIDTH{1'b0}};
            r_pstrb       <= {STRB_W{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_paddr   <= cmd_addr_i;
                        r_pprot   <= cmd_prot_i;
                        r_pwrite  <= cmd_write_i;
                        r_pwdata  <= cmd_wdata_i;
                        r_pstrb   <= cmd_write_i ? cmd_strb_i : {STRB_W{1'b0}};
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= {CNT_W{1'b0}};
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        r_rsp_rdata   <= r_pwrite ? {DATA_WIDTH{1'b0}} : prdata_i;
                        r_rsp_err     <= pslverr_i;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_expired) begin
                        r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (r_state == IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign paddr_o       = r_paddr;
    assign pprot_o       = r_pprot;
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign pwrite_o      = r_pwrite;
    assign pwdata_o      = r_pwdata;
    assign pstrb_o       = r_pstrb;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench for apb4_cmd_master: expected responses go into a scoreboard
// queue at issue time, an independent monitor pops them on each response handshake.
module tb_apb4_cmd_master;
    import apb4_cmd_master_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i = 32'h0;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic [3:0]  cmd_strb_i = 4'h0;
    logic [2:0]  cmd_prot_i = 3'b000;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] paddr_o;
    logic [2:0]  pprot_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i = 1'b0;
    logic [31:0] prdata_i = 32'h0;
    logic        pslverr_i = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    // Slave behaviour knobs
    int          slave_ws    = 0;
    int          wait_cnt    = 0;
    logic        slave_err   = 1'b0;
    logic        slave_hang  = 1'b0;
    logic        slave_fixed = 1'b0;
    logic [31:0] fixed_val   = 32'h0;
    logic        late_pready = 1'b0;

    apb4_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_write_i(cmd_write_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i), .cmd_prot_i(cmd_prot_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'hA500_0000 | (a << 8) | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input logic to);
        rsp_t e;
        e.rdata   = rdata;
        e.err     = err;
        e.timeout = to;
        exp_q.push_back(e);
    endtask

    // Issue a command; returns in the cycle after acceptance (PSEL cycle).
    task automatic send_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p, output int acc_cyc);
        bit done;
        done        = 1'b0;
        acc_cyc     = -1;
        cmd_addr_i  = a;
        cmd_write_i = w;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
        cmd_prot_i  = p;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (cmd_ready_o) done = 1'b1;
            tick();
        end
        cmd_valid_i = 1'b0;
        if (done) acc_cyc = cyc;
        else begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_accept: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("drain_q_empty", exp_q.size(), 0);
    endtask

    // APB slave model: programmable wait states, error, hang and late PREADY.
    always @(negedge clk_i) begin
        if (late_pready) begin
            pready_i  = 1'b1;
            prdata_i  = 32'hFFFF_FFFF;
            pslverr_i = 1'b0;
        end else if (psel_o && penable_o && !slave_hang) begin
            if (wait_cnt == slave_ws) begin
                pready_i  = 1'b1;
                prdata_i  = slave_fixed ? fixed_val : mem_val(paddr_o);
                pslverr_i = slave_err;
                wait_cnt  = 0;
            end else begin
                pready_i  = 1'b0;
                prdata_i  = 32'h0;
                pslverr_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            pready_i  = 1'b0;
            prdata_i  = 32'h0;
            pslverr_i = 1'b0;
            if (!(psel_o && penable_o)) wait_cnt = 0;
        end
    end

    // Response monitor / scoreboard
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got response rdata=%h expected none", rsp_rdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata",   rsp_rdata_o,   mon_e.rdata);
                check("rsp_err",     rsp_err_o,     mon_e.err);
                check("rsp_timeout", rsp_timeout_o, mon_e.timeout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int prev;
        int cnt;
        int k;

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_paddr", paddr_o, 32'h0);
        check("rst_pstrb", pstrb_o, 4'h0);
        check("rst_rsp_err", rsp_err_o, 0);

        // Async reset in the middle of an ACCESS phase
        slave_hang = 1'b1;
        send_cmd(32'h0000_0010, 1'b1, 32'h1111_2222, 4'hF, 3'b000, acc);
        tick();
        check("mid_penable_before", penable_o, 1);
        #3 rst_i = 1'b1;
        #1;
        check("mid_rst_psel", psel_o, 0);
        check("mid_rst_penable", penable_o, 0);
        check("mid_rst_rsp_valid", rsp_valid_o, 0);
        tick();
        rst_i = 1'b0;
        slave_hang = 1'b0;
        tick();
        check("mid_rst_cmd_ready", cmd_ready_o, 1);

        // Zero-wait read: latency and forced-zero strobe
        rsp_ready_i = 1'b1;
        slave_fixed = 1'b1;
        fixed_val   = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        send_cmd(32'h0000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010, acc);
        check("rd_n1_psel", psel_o, 1);
        check("rd_n1_penable", penable_o, 0);
        check("rd_pstrb", pstrb_o, 4'h0);
        check("rd_paddr", paddr_o, 32'h0000_0004);
        check("rd_pprot", pprot_o, 3'b010);
        check("rd_pwrite", pwrite_o, 0);
        tick();
        check("rd_n2_penable", penable_o, 1);
        check("rd_n2_rsp_valid", rsp_valid_o, 0);
        tick();
        check("rd_n3_rsp_valid", rsp_valid_o, 1);
        check("rd_n3_psel", psel_o, 0);
        drain();
        slave_fixed = 1'b0;

        // Write with three wait states and PSLVERR
        slave_ws  = 3;
        slave_err = 1'b1;
        push_exp(32'h0, 1'b1, 1'b0);
        send_cmd(32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, acc);
        check("wr_pstrb", pstrb_o, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("wr_paddr_stable", paddr_o, 32'h0000_0008);
            check("wr_pwdata_stable", pwdata_o, 32'hDEAD_BEEF);
            check("wr_psel_stable", psel_o, 1);
            tick();
        end
        check("wr_rsp_valid", rsp_valid_o, 1);
        check("wr_psel_drop", psel_o, 0);
        drain();
        slave_ws  = 0;
        slave_err = 1'b0;

        // Timeout abort, late PREADY ignored while response is held
        rsp_ready_i = 1'b0;
        slave_hang  = 1'b1;
        push_exp(32'h0, 1'b1, 1'b1);
        send_cmd(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000, acc);
        tick();
        cnt = 0;
        for (int i = 0; i < 50 && psel_o && penable_o; i++) begin
            cnt++;
            tick();
        end
        check("to_access_cycles", cnt, 8);
        check("to_rsp_valid", rsp_valid_o, 1);
        late_pready = 1'b1;
        repeat (3) tick();
        check("to_late_rdata", rsp_rdata_o, 32'h0);
        check("to_late_timeout", rsp_timeout_o, 1);
        check("to_late_err", rsp_err_o, 1);
        check("to_late_valid", rsp_valid_o, 1);
        late_pready = 1'b0;
        slave_hang  = 1'b0;
        rsp_ready_i = 1'b1;
        drain();
        repeat (3) tick();

        // Response back-pressure with the next command already pending
        rsp_ready_i = 1'b0;
        push_exp(mem_val(32'h0000_000C), 1'b0, 1'b0);
        send_cmd(32'h0000_000C, 1'b0, 32'h0, 4'h0, 3'b000, acc);
        push_exp(mem_val(32'h0000_0030), 1'b0, 1'b0);
        cmd_addr_i  = 32'h0000_0030;
        cmd_write_i = 1'b0;
        cmd_valid_i = 1'b1;
        for (k = 0; k < 50 && !rsp_valid_o; k++) tick();
        check("hold_rsp_seen", rsp_valid_o, 1);
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", rsp_valid_o, 1);
            check("hold_rsp_rdata", rsp_rdata_o, mem_val(32'h0000_000C));
            check("hold_cmd_ready", cmd_ready_o, 0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        check("hold_next_ready", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        check("hold_next_psel", psel_o, 1);
        check("hold_next_paddr", paddr_o, 32'h0000_0030);
        drain();

        // Sixteen back-to-back zero-wait reads
        prev = -1;
        for (int i = 0; i < 16; i++) begin
            push_exp(mem_val(32'(i * 4)), 1'b0, 1'b0);
            send_cmd(32'(i * 4), 1'b0, 32'h0, 4'h0, 3'b000, acc);
            if (prev >= 0) check("b2b_spacing", acc - prev, 4);
            prev = acc;
        end
        drain();
        repeat (3) tick();
        check("final_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
